spi_peripheral: RTL and testbench

Write-only SPI (mode 0) register interface that sits directly upstream of the PWM peripheral inside the onboarding top level. It receives 16-bit frames from an external controller on the `ui_in` pins and updates five 8-bit configuration registers. The PWM block consumes these registers, which set per-pin output enables, per-pin PWM enables and the shared duty cycle. All SPI pins are asynchronous to `clk` and are oversampled, so no SPI-clocked logic exists.

---
 rtl/onboarding_pkg.sv | 24 ++
 rtl/spi_peripheral_if.sv | 26 ++
 rtl/spi_peripheral_sync_ff.sv | 27 ++
 rtl/spi_peripheral.sv | 140 ++++++++++++++
 tb/tb_spi_peripheral.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/onboarding_pkg.sv
// Shared register map and SPI FSM state encoding for the onboarding top level.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package onboarding_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam logic [6:0] MAX_ADDR       = 7'h04;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

    // True when an address maps onto one of the configuration registers.
    function automatic logic addr_in_map(input logic [6:0] addr);
        return addr <= MAX_ADDR;
    endfunction

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pins plus the configuration register outputs consumed by the PWM block.
// Latency: n/a (wiring only).
// Backpressure: none; SPI is write-only and the register outputs are level signals.
interface spi_peripheral_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, wr_strobe
    );

    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, wr_strobe
    );
endinterface

// File: rtl/spi_peripheral_sync_ff.sv
// Multi-flop synchroniser bringing an asynchronous pin into the clk domain.
// Latency: DEPTH clk cycles.
// Backpressure: none.
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    // Shift the raw pin through the chain; only the last stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {DEPTH{RESET_VAL}};
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target, oversampled on clk, updating five 8-bit config registers.
// Latency: raw ncs rise to register update and wr_strobe is SYNC_STAGES+2 clk cycles.
// Backpressure: none; malformed, read or out-of-map frames are silently dropped.
module spi_peripheral
    import onboarding_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_peripheral_if.slave   bus
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic sclk_sync;
    logic copi_sync;
    logic ncs_sync;
    logic sclk_hist;
    logic ncs_hist;

    // ncs chain resets to "selected" so a frame already in progress at reset
    // release produces no falling edge and is ignored until ncs cycles.
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(sclk_sync)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(bus.copi), .q(copi_sync)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(bus.ncs), .q(ncs_sync)
    );

    // History flops for edge detection on the synchronised sclk and ncs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b0;
        end else begin
            sclk_hist <= sclk_sync;
            ncs_hist  <= ncs_sync;
        end
    end

    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    assign sclk_rise = sclk_sync & ~sclk_hist;
    assign ncs_fall  = ~ncs_sync & ncs_hist;
    assign ncs_rise  = ncs_sync & ~ncs_hist;

    spi_state_t            state;
    logic [FRAME_BITS-1:0] shift;
    logic [4:0]            count;
    logic [7:0]            en_out_lo;
    logic [7:0]            en_out_hi;
    logic [7:0]            en_pwm_lo;
    logic [7:0]            en_pwm_hi;
    logic [7:0]            duty;
    logic                  wr_strobe;

    logic                  frame_wr;
    logic [6:0]            frame_addr;
    logic [7:0]            frame_dat;
    logic                  frame_ok;

    assign frame_wr   = shift[FRAME_BITS-1];
    assign frame_addr = shift[FRAME_BITS-2 -: 7];
    assign frame_dat  = shift[7:0];
    assign frame_ok   = (count == FRAME_CNT) && frame_wr && addr_in_map(frame_addr);

    // Frame FSM: collect bits while selected, then commit one register write on deselect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            count     <= '0;
            en_out_lo <= 8'h00;
            en_out_hi <= 8'h00;
            en_pwm_lo <= 8'h00;
            en_pwm_hi <= 8'h00;
            duty      <= 8'h00;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state <= SHIFT;
                        shift <= '0;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    // Deselect wins over a coincident sclk edge.
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        shift <= {shift[FRAME_BITS-2:0], copi_sync};
                        if (count != 5'd31) begin
                            count <= count + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (frame_ok) begin
                        wr_strobe <= 1'b1;
                        case (frame_addr)
                            ADDR_EN_OUT_LO: en_out_lo <= frame_dat;
                            ADDR_EN_OUT_HI: en_out_hi <= frame_dat;
                            ADDR_EN_PWM_LO: en_pwm_lo <= frame_dat;
                            ADDR_EN_PWM_HI: en_pwm_hi <= frame_dat;
                            ADDR_DUTY:      duty      <= frame_dat;
                            default:        ;
                        endcase
                    end
                    // A new select arriving here still lets this commit finish first.
                    if (ncs_fall) begin
                        state <= SHIFT;
                        shift <= '0;
                        count <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.en_reg_out_7_0  = en_out_lo;
    assign bus.en_reg_out_15_8 = en_out_hi;
    assign bus.en_reg_pwm_7_0  = en_pwm_lo;
    assign bus.en_reg_pwm_15_8 = en_pwm_hi;
    assign bus.pwm_duty_cycle  = duty;
    assign bus.wr_strobe       = wr_strobe;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: bit-banged SPI frames with hand-computed register values.
// Latency: checks wr_strobe lands exactly 4 clk cycles after ncs rises.
// Backpressure: n/a.
module tb_spi_peripheral;
    import onboarding_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   strobe_cnt = 0;
    int   cnt_before;

    always #5 clk = ~clk;

    spi_peripheral_if bus();

    spi_peripheral #(
        .SYNC_STAGES(2),
        .FRAME_BITS(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Count every strobe cycle independently of the frame tasks.
    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) strobe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, leaving time 1 unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        check_eq({tag, " out_lo"}, bus.en_reg_out_7_0,  e0);
        check_eq({tag, " out_hi"}, bus.en_reg_out_15_8, e1);
        check_eq({tag, " pwm_lo"}, bus.en_reg_pwm_7_0,  e2);
        check_eq({tag, " pwm_hi"}, bus.en_reg_pwm_15_8, e3);
        check_eq({tag, " duty"},   bus.pwm_duty_cycle,  e4);
    endtask

    // Send nbits of val MSB first. half = sclk phase length in clk cycles;
    // off shifts the copi change point relative to the sclk falling edge;
    // abort_bit >= 0 pulses rst_n low just before that bit; gap = ncs-high
    // cycles afterwards, during which wr_strobe is checked cycle by cycle.
    task automatic send_frame(input logic [31:0] val, input int nbits, input int half,
                              input int off, input int abort_bit, input int gap,
                              input logic expect_wr, input string tag);
        int total;
        int k;
        total    = nbits * 2 * half;
        bus.ncs  = 1'b0;
        bus.sclk = 1'b0;
        for (int g = 0; g < total; g++) begin
            if (abort_bit >= 0 && g == abort_bit * 2 * half) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            bus.sclk = ((g % (2 * half)) >= half);
            k = (g - off < 0) ? 0 : (g - off) / (2 * half);
            if (k < nbits) bus.copi = val[nbits - 1 - k];
            cyc(1);
        end
        bus.sclk = 1'b0;
        cyc(half);
        bus.ncs = 1'b1;
        for (int c = 1; c <= gap; c++) begin
            cyc(1);
            if (c <= 6) check_eq($sformatf("%s strobe c%0d", tag, c), bus.wr_strobe,
                                 (expect_wr && c == 4) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.ncs  = 1'b1;
        bus.sclk = 1'b0;
        bus.copi = 1'b0;

        // Reset state.
        cyc(5);
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("reset strobe", bus.wr_strobe, 32'd0);
        rst_n = 1'b1;
        cyc(5);
        check_eq("post-reset strobe", bus.wr_strobe, 32'd0);

        // Write every address.
        cnt_before = strobe_cnt;
        send_frame(32'h80F0, 16, 4, 0, -1, 6, 1'b1, "wr00");
        send_frame(32'h81CC, 16, 4, 0, -1, 6, 1'b1, "wr01");
        send_frame(32'h820F, 16, 4, 0, -1, 6, 1'b1, "wr02");
        send_frame(32'h8333, 16, 4, 0, -1, 6, 1'b1, "wr03");
        send_frame(32'h8480, 16, 4, 0, -1, 6, 1'b1, "wr04");
        check_regs("all", 8'hF0, 8'hCC, 8'h0F, 8'h33, 8'h80);
        check_eq("all strobes", strobe_cnt - cnt_before, 32'd5);

        // Ignored frames.
        cnt_before = strobe_cnt;
        send_frame(32'hB0AA,  16, 4, 0, -1, 6, 1'b0, "addr30");
        send_frame(32'h8577,  16, 4, 0, -1, 6, 1'b0, "addr05");
        send_frame(32'h0055,  16, 4, 0, -1, 6, 1'b0, "read");
        send_frame(32'h402A,  15, 4, 0, -1, 6, 1'b0, "short");
        send_frame(32'h08155, 17, 4, 0, -1, 6, 1'b0, "long");
        check_regs("ignored", 8'hF0, 8'hCC, 8'h0F, 8'h33, 8'h80);
        check_eq("ignored strobes", strobe_cnt - cnt_before, 32'd0);

        // Back-to-back writes with minimum inter-frame gap.
        cnt_before = strobe_cnt;
        send_frame(32'h8410, 16, 4, 0, -1, 4, 1'b1, "b2b1");
        send_frame(32'h8420, 16, 4, 0, -1, 6, 1'b1, "b2b2");
        check_eq("b2b duty", bus.pwm_duty_cycle, 32'h20);
        check_eq("b2b strobes", strobe_cnt - cnt_before, 32'd2);

        // Mid-frame reset: rest of the frame must be ignored.
        cnt_before = strobe_cnt;
        send_frame(32'h8255, 16, 4, 0, 8, 6, 1'b0, "abort");
        check_regs("abort", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_eq("abort strobes", strobe_cnt - cnt_before, 32'd0);
        send_frame(32'h8255, 16, 4, 0, -1, 6, 1'b1, "rewr");
        check_eq("rewr pwm_lo", bus.en_reg_pwm_7_0, 32'h55);

        // Minimum sclk phase with copi moved a cycle either side.
        send_frame(32'h80A5, 16, 3, -1, -1, 6, 1'b1, "min_m1");
        send_frame(32'h815A, 16, 3,  1, -1, 6, 1'b1, "min_p1");
        send_frame(32'h843C, 16, 3,  0, -1, 6, 1'b1, "min_0");
        check_regs("minphase", 8'hA5, 8'h5A, 8'h55, 8'h00, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
